// File: rtl/count_stream_checker_if.sv
// Bus between a count source and the count_stream_checker.
// The source drives en, count and clr_err; the checker returns lock and error status.
interface count_stream_checker_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 en;
  logic [WIDTH-1:0]     count;
  logic                 clr_err;
  logic                 locked;
  logic                 err_pulse;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0]     expected;

  modport master (
    output en, count, clr_err,
    input  locked, err_pulse, err_sticky, err_cnt, expected
  );

  modport slave (
    input  en, count, clr_err,
    output locked, err_pulse, err_sticky, err_cnt, expected
  );
endinterface

// File: rtl/count_stream_checker.sv
// Sequence checker for a free-running +1 counter: locks onto the stream, then flags deviations.
// Optional macro COUNT_CHK_RESYNC_EN: on a mismatch drop lock and reacquire instead of re-seeding.
module count_stream_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned LOCK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  count_stream_checker_if.slave   bus
);

  localparam int unsigned MATCH_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     count_inc;
  logic [ERR_CNT_W-1:0] err_base;
  logic                 step_ok;

  // State and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      match_q      <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_q      <= match_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state and output logic; a mismatch on the same edge as clr_err counts from zero
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    match_d      = match_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    count_inc    = bus.count + WIDTH'(1);
    step_ok      = (bus.count == (prev_q + WIDTH'(1)));
    err_base     = bus.clr_err ? '0 : err_cnt_q;
    err_sticky_d = bus.clr_err ? 1'b0 : err_sticky_q;
    err_cnt_d    = err_base;

    if (!bus.en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ACQUIRE;
          prev_d   = bus.count;
          match_d  = '0;
          locked_d = 1'b0;
        end
        ACQUIRE: begin
          prev_d   = bus.count;
          locked_d = 1'b0;
          if (step_ok) begin
            match_d = match_q + MATCH_W'(1);
            if ((match_q + MATCH_W'(1)) == MATCH_W'(LOCK_CYCLES)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              expected_d = count_inc;
              match_d    = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          locked_d = 1'b1;
          if (bus.count == expected_q) begin
            expected_d = count_inc;
          end else begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            err_cnt_d    = (&err_base) ? err_base : err_base + ERR_CNT_W'(1);
`ifdef COUNT_CHK_RESYNC_EN
            state_d  = ACQUIRE;
            locked_d = 1'b0;
            prev_d   = bus.count;
            match_d  = '0;
`else
            expected_d = count_inc;
`endif
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.expected   = expected_q;

endmodule
